// File: rtl/gpio_bus_arb.sv
// Two-master arbiter/sequencer for the GPIO register port.
// Define GPIO_ARB_FIXED_PRIO_EN for fixed priority (master 0 wins).
module gpio_bus_arb #(
  parameter int DW = 32,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          sel,
  output logic          wr_en,
  output logic          rd_en,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wdata,
  input  logic [DW-1:0] rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, RESP, ACK
  } state_e;

  state_e        state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          sel_q, sel_d;
  logic          wr_q, wr_d;
  logic          rd_q, rd_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [DW-1:0] rdat0_q, rdat0_d;
  logic [DW-1:0] rdat1_q, rdat1_d;
  logic          win;
  logic          win_we;

`ifdef GPIO_ARB_FIXED_PRIO_EN
  assign win = ~m0_req;
`else
  logic last_q, last_d;

  // Round-robin: on contention the master not served last wins.
  assign win = (m0_req && m1_req) ? ~last_q : m1_req;
`endif

  assign win_we = win ? m1_we : m0_we;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = 1'b0;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    rdat0_d = rdat0_q;
    rdat1_d = rdat1_q;
`ifndef GPIO_ARB_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          gnt_d   = win;
          we_d    = win_we;
          addr_d  = win ? m1_addr : m0_addr;
          wdata_d = win ? m1_wdata : m0_wdata;
          sel_d   = 1'b1;
          wr_d    = win_we;
          rd_d    = ~win_we;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = RESP;
      RESP: begin
        if (!we_q) begin
          if (gnt_q) rdat1_d = rdata;
          else       rdat0_d = rdata;
        end
        ack0_d  = ~gnt_q;
        ack1_d  = gnt_q;
        state_d = ACK;
      end
      ACK: begin
`ifndef GPIO_ARB_FIXED_PRIO_EN
        last_d  = gnt_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rdat0_q <= '0;
      rdat1_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      rdat0_q <= rdat0_d;
      rdat1_q <= rdat1_d;
    end
  end

`ifndef GPIO_ARB_FIXED_PRIO_EN
  // Starts at 1 so master 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end
`endif

  assign sel      = sel_q;
  assign wr_en    = wr_q;
  assign rd_en    = rd_q;
  assign addr     = addr_q;
  assign wdata    = wdata_q;
  assign m0_ack   = ack0_q;
  assign m1_ack   = ack1_q;
  assign m0_rdata = rdat0_q;
  assign m1_rdata = rdat1_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: doc/gpio_bus_arb.md
# gpio_bus_arb

Two-requester arbiter and sequencer for the GPIO controller register port. It accepts register read/write commands from two independent masters (e.g. CPU bus bridge and a hardware pattern engine) and serializes them onto the single GPIO bus. It generates the one-cycle `sel`/`wr_en`/`rd_en` strobe and captures the GPIO controller's registered read data. It returns a one-cycle `ack` with read data to the winning master.

## Interface
Parameters:
- `DW`, 32, data width of `wdata`/`rdata`.
- `AW`, 2, register address width.

Ports (N = 0, 1; one set per master):
- `clk` input 1: single clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `mN_req` input 1: master N requests a transaction; held with command stable until `mN_ack`.
- `mN_we` input 1: 1 = write, 0 = read.
- `mN_addr` input AW: GPIO register select.
- `mN_wdata` input DW: write data.
- `mN_ack` output 1: one-cycle completion pulse.
- `mN_rdata` output DW: read data, valid when `mN_ack`=1, held until next ack to master N.
- `sel` output 1: GPIO select strobe.
- `wr_en` output 1: GPIO write enable.
- `rd_en` output 1: GPIO read enable.
- `addr` output AW: GPIO register address.
- `wdata` output DW: GPIO write data.
- `rdata` input DW: GPIO read data (registered in GPIO, valid 1 cycle after read strobe).
- `busy` output 1: high in any state other than IDLE.

## Operation
- FSM states are IDLE, ISSUE, RESP, ACK, with one transaction per pass.
- IDLE: if any `mN_req`=1, select a winner, latch its `we`/`addr`/`wdata` into command registers, and register `gnt_id`. Register the bus outputs `sel`=1, `wr_en`=`we`, `rd_en`=~`we`, `addr`, `wdata`, then go to ISSUE. With no request, stay in IDLE.
- ISSUE: strobes are high for exactly this cycle; the GPIO samples at the ending edge. Clear `sel`/`wr_en`/`rd_en` and go to RESP. `addr`/`wdata` keep their last value.
- RESP: GPIO `rdata` is valid. For a read, load `m[gnt_id]_rdata` <= `rdata`; for a write, leave `mN_rdata` unchanged. Set `m[gnt_id]_ack` and go to ACK.
- ACK: `m[gnt_id]_ack`=1 for this cycle only. Requests are ignored. Update `last_gnt` <= `gnt_id` and go to IDLE.
- Arbitration (default round-robin): if only one master requests, it wins. If both request, the master != `last_gnt` wins.
- The master must drop `req` on the edge ending its ACK cycle. A `req` still high in the following IDLE cycle starts a new transaction.
- `addr` values 2 and 3 are passed through unchanged; the GPIO defines their semantics (write ignored, read returns pin state or 0).
- `wr_en` and `rd_en` are never high together; `sel` is never high outside ISSUE.

## Timing
- Reset values: `sel`=`wr_en`=`rd_en`=0, `addr`=0, `wdata`=0, `mN_ack`=0, `mN_rdata`=0, `busy`=0, state=IDLE, `last_gnt`=1 (so master 0 wins the first contention).
- Latency: with `req` high in IDLE cycle T, strobes are high in T+1, read data is captured at the end of T+2, and `ack` is high in T+3.
- Throughput is one transaction per 4 cycles. With both masters continuously requesting, grants alternate 0,1,0,1.
- A request that arrives while `busy`=1 waits. It is never dropped, and no more than one transaction per master is in flight.
- Reset in any state: next cycle is IDLE with all outputs at reset values. The aborted transaction gets no `ack`, and its master must re-request.
- `mN_ack` and `sel` never overlap. At most one `mN_ack` is high per cycle.

## Configuration
- `GPIO_ARB_FIXED_PRIO_EN`, when defined: fixed priority, master 0 always wins contention. `last_gnt` is not implemented. Master 1 can starve under continuous master 0 traffic.
- When not defined: round-robin as described under Operation.

## Test plan
- Write: m0 write addr=1 wdata=0x0000_00FF -> one cycle of `sel`=`wr_en`=1, `addr`=1, `wdata`=0xFF in T+1; `m0_ack` in T+3; `m0_rdata` unchanged (0).
- Read-back: after the above, m1 read addr=1 -> `rd_en`=1 in T+1; `m1_ack` in T+3 with `m1_rdata`=0x0000_00FF; `m0_rdata` still 0.
- Contention after reset: m0 and m1 request in the same cycle -> m0 acked first, m1 acked 4 cycles later. Both held continuously afterwards -> grant order 0,1,0,1.
- Pin read: gpio_dir=0x0F, gpio_data=0xFF, gpio_in=0xA0, m0 read addr=2 -> `m0_rdata`=0x0000_00AF.
- Reset mid-op: assert `reset` during the ISSUE cycle -> strobes 0 the next cycle, no `ack` ever issued, `busy`=0. Re-request completes normally with m0 winning.
- `GPIO_ARB_FIXED_PRIO_EN` build: both masters request continuously for 12 cycles -> three m0 acks and zero m1 acks. m1 is served once m0 drops `req`.
